instr_issue_unit: RTL

- Producer side of the 3-stage datapath's instruction port: buffers instructions from a loader (valid/ready), issues one instruction word per cycle to the pipeline's instruction input, and inserts NOPs to resolve RAW hazards, since the datapath has no forwarding.
- Also watches the pipeline's writeback output and reports each retired write as a tagged result beat.
- Sits between the test/program loader and the pipeline top.

---
 rtl/instr_issue_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/instr_issue_unit.sv
// Instruction issue unit: buffers loader instructions in a FIFO and issues
// one word per cycle to a 3-stage pipeline that has no forwarding. NOPs are
// inserted while the FIFO head reads a register written by a recent issue.
// Retired writes are reported as tagged result beats sampled from pipe_out.
module instr_issue_unit #(
  parameter int DEPTH      = 8,
  parameter int HAZ_DEPTH  = 3,
  parameter int RESULT_LAT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  input  logic                     run,
  output logic [31:0]              issue_instr,
  input  logic [31:0]              pipe_out,
  output logic                     res_valid,
  output logic [4:0]               res_ws,
  output logic [31:0]              res_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              stall_count,
  output logic                     idle
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          sb_we [HAZ_DEPTH];
  logic [4:0]    sb_ws [HAZ_DEPTH];
  logic          rl_we [RESULT_LAT];
  logic [4:0]    rl_ws [RESULT_LAT];

  logic [31:0]   head;
  logic          fifo_empty;
  logic          hazard;
  logic          inflight;
  logic          push;
  logic          issue_now;

  assign head       = mem[rd_ptr];
  assign fifo_empty = (fifo_count == '0);
  assign in_ready   = (fifo_count < ($clog2(DEPTH)+1)'(DEPTH));
  assign push       = in_valid && in_ready;
  assign issue_now  = run && !fifo_empty && !hazard;
  assign idle       = fifo_empty && !inflight;

  // Head is blocked if any recent write targets one of the registers it reads
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (sb_we[i] && ((sb_ws[i] == head[21:17]) ||
                       (!head[28] && (sb_ws[i] == head[15:11])))) begin
        hazard = 1'b1;
      end
    end
  end

  // Any pending write in the scoreboard or the result line keeps the unit busy
  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (sb_we[i]) inflight = 1'b1;
    end
    for (int i = 0; i < RESULT_LAT; i++) begin
      if (rl_we[i]) inflight = 1'b1;
    end
  end

  // FIFO storage carries no reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + AW'(1);
      if (issue_now) rd_ptr <= rd_ptr + AW'(1);
      case ({push, issue_now})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Issue stage, hazard scoreboard, result delay line and result beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_instr <= '0;
      res_valid   <= 1'b0;
      res_ws      <= '0;
      res_data    <= '0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
        sb_we[i] <= 1'b0;
        sb_ws[i] <= '0;
      end
      for (int i = 0; i < RESULT_LAT; i++) begin
        rl_we[i] <= 1'b0;
        rl_ws[i] <= '0;
      end
    end else begin
      issue_instr <= issue_now ? head : 32'h0000_0000;
      sb_we[0]    <= issue_now && head[27];
      sb_ws[0]    <= issue_now ? head[26:22] : 5'd0;
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        sb_we[i] <= sb_we[i-1];
        sb_ws[i] <= sb_ws[i-1];
      end
      rl_we[0] <= issue_instr[27];
      rl_ws[0] <= issue_instr[26:22];
      for (int i = 1; i < RESULT_LAT; i++) begin
        rl_we[i] <= rl_we[i-1];
        rl_ws[i] <= rl_ws[i-1];
      end
      if (rl_we[RESULT_LAT-1]) begin
        res_valid <= 1'b1;
        res_ws    <= rl_ws[RESULT_LAT-1];
        res_data  <= pipe_out;
      end else begin
        res_valid <= 1'b0;
      end
    end
  end

  // Saturating count of cycles the head was held back by a hazard
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (run && !fifo_empty && hazard && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule
